dp_sink_responder: RTL
======================

Name: dp_sink_responder

Overview:
- Synthesizable slave/responder end of the valid/ready/pd data-path protocol.
- Accepts beats from a dp master and generates programmable backpressure on `dp_ready`.
- Buffers accepted beats in a small FIFO, which drains to a local output.
- Counts handshakes and flags master-side protocol violations; used in unit benches and as a stand-in sink at partition boundaries.

Parameters:
- PW, 1, payload width of `dp_pd`
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- BP_SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- dp_valid  in  1  master beat valid
- dp_ready  out  1  sink ready (registered)
- dp_pd  in  PW  master payload
- bp_mode  in  2  00 ready-if-space, 01 LFSR random, 10 periodic, 11 never ready
- bp_period  in  4  periodic mode: ready 1 cycle in (bp_period+1)
- drain_en  in  1  pop one FIFO entry per cycle when out_valid
- out_valid  out  1  FIFO non-empty
- out_pd  out  PW  FIFO head payload
- txn_count  out  32  accepted handshake count
- err_valid_drop  out  1  sticky: valid deasserted while stalled
- err_pd_change  out  1  sticky: pd changed while stalled
- err_pd_x  out  1  sticky: unknown pd accepted (optional feature)
- clr  in  1  synchronous clear of txn_count and all err_* flags

Behaviour:
- Reset, sampled at posedge clk when resetn=0:
  - dp_ready=0, out_valid=0, out_pd=0
  - txn_count=0, all err_*=0
  - FIFO empty; LFSR=BP_SEED; period counter=0
  - First possible dp_ready=1 is the cycle after the first resetn=1 edge.
- Handshake: accept = dp_valid & dp_ready at posedge.
  - Pushes dp_pd into the FIFO and increments txn_count.
  - txn_count wraps 32'hFFFFFFFF→0.
- dp_ready is registered: next = allow_next & (occ_next < DEPTH).
  - occ_next = occ + accept − pop.
  - The FIFO never overflows; a push while full is impossible by construction.
- Pop = drain_en & out_valid.
  - out_pd is the FIFO head, valid combinationally with out_valid.
  - Push and pop in the same cycle: occupancy unchanged; order preserved.
  - Pop on the last entry with no push: out_valid=0 the next cycle.
  - Push into an empty FIFO: out_valid=1 the next cycle (1-cycle latency in→out).
- Backpressure allow_next by bp_mode:
  - 00: 1.
  - 01: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifted every cycle in this mode; allow = lfsr[0].
  - 10: counter 0..bp_period, wrapping; allow when counter==0; bp_period=0 means always allow.
  - 11: 0.
  - A bp_mode change takes effect on the next dp_ready update. The LFSR and period counter hold when not in their mode.
- Stall tracking: stalled_q <= dp_valid & ~dp_ready; held_pd_q <= dp_pd.
  - If stalled_q and ~dp_valid: set err_valid_drop.
  - If stalled_q and dp_valid and dp_pd != held_pd_q: set err_pd_change.
- Error flags are sticky until clr or reset.
  - clr has priority over a same-cycle set.
  - txn_count cleared by clr does not count a same-cycle accept (result 0).
- dp_ready may deassert without an accept; the sink places no restriction on its own ready.
- Reset mid-stream: FIFO contents are discarded and beats in flight are lost; the master must re-present them after reset.

Optional Feature:
- Macro: DP_SINK_XCHECK_EN.
- Defined:
  - Every accepted beat with $isunknown(dp_pd) sets err_pd_x, sticky and clearable by clr.
  - A simulation assertion also fires on accept with unknown pd (disabled while !resetn).
  - Not for synthesis.
- Undefined: err_pd_x tied 0; no checking logic.

Test Plan:
- Mode 00, DEPTH=4, drain_en=1, master streams 16 beats pd=0..15 back-to-back → out_pd sequence 0..15 with no gaps after the first, txn_count=16, no errors.
- Mode 00, drain_en=0, master pushes continuously → exactly 4 accepts, dp_ready=0 from the cycle after the 4th; drain_en=1 for one cycle → dp_ready=1 the next cycle, 5th beat accepted.
- Mode 10, bp_period=3, master always valid, drain_en=1 → dp_ready high exactly 1 of every 4 cycles; txn_count=25 after 100 ready-cycles window.
- Mode 11, master asserts valid pd=8'hA5 then drops valid with no handshake → err_valid_drop=1; clr pulse → 0. Separate run: pd changes A5→5A while stalled → err_pd_change=1.
- Mode 01, BP_SEED=16'hACE1, 1000 cycles always valid → dp_ready pattern matches reference LFSR model bit-for-bit; all accepted pd emerge in order.
- DP_SINK_XCHECK_EN defined, accept beat pd='x → err_pd_x=1 next cycle; with macro undefined → err_pd_x stays 0.

Source files
------------

// File: rtl/dp_sink_responder.sv
// dp_sink_responder: responder end of the valid/ready/pd data path.
// It accepts beats under programmable backpressure and buffers them in a
// small FIFO that drains to a local output. It also counts handshakes and
// keeps sticky flags for master-side protocol violations.
// Optional feature macro: DP_SINK_XCHECK_EN. When defined, accepted payloads
// holding X/Z set err_pd_x and trip an assertion (simulation only).
// When undefined, err_pd_x is tied 0.
module dp_sink_responder #(
    parameter int          PW      = 1,
    parameter int          DEPTH   = 4,
    parameter logic [15:0] BP_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          dp_valid,
    output logic          dp_ready,
    input  logic [PW-1:0] dp_pd,
    input  logic [1:0]    bp_mode,
    input  logic [3:0]    bp_period,
    input  logic          drain_en,
    output logic          out_valid,
    output logic [PW-1:0] out_pd,
    output logic [31:0]   txn_count,
    output logic          err_valid_drop,
    output logic          err_pd_change,
    output logic          err_pd_x,
    input  logic          clr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_next;
    logic          accept, pop, allow_next;
    logic [15:0]   lfsr_q, lfsr_next;
    logic [3:0]    per_cnt, per_cnt_next;
    logic          dp_ready_q, stalled_q;
    logic [PW-1:0] held_pd_q;
    logic [31:0]   txn_q;
    logic          err_vd_q, err_pc_q;

    assign dp_ready       = dp_ready_q;
    assign accept         = dp_valid & dp_ready_q;
    assign out_valid      = (occ != '0);
    assign pop            = drain_en & out_valid;
    // Gate the head so an empty FIFO shows zero instead of a stale entry.
    assign out_pd         = out_valid ? mem[rd_ptr] : '0;
    assign occ_next       = occ + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    assign txn_count      = txn_q;
    assign err_valid_drop = err_vd_q;
    assign err_pd_change  = err_pc_q;

    // Backpressure source for the next ready. Each generator advances only in its own mode.
    always_comb begin
        allow_next   = 1'b1;
        lfsr_next    = lfsr_q;
        per_cnt_next = per_cnt;
        case (bp_mode)
            2'b00: allow_next = 1'b1;
            2'b01: begin
                allow_next = lfsr_q[0];
                lfsr_next  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            end
            2'b10: begin
                allow_next   = (per_cnt == 4'd0);
                per_cnt_next = (per_cnt >= bp_period) ? 4'd0 : per_cnt + 4'd1;
            end
            default: allow_next = 1'b0;
        endcase
    end

    // FIFO storage. Ready is never high while full, so a push always has room.
    always_ff @(posedge clk) begin
        if (resetn && accept) mem[wr_ptr] <= dp_pd;
    end

    // Control state: pointers, registered ready, generators, counters and stall tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            dp_ready_q <= 1'b0;
            lfsr_q     <= BP_SEED;
            per_cnt    <= 4'd0;
            stalled_q  <= 1'b0;
            held_pd_q  <= '0;
            txn_q      <= '0;
            err_vd_q   <= 1'b0;
            err_pc_q   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            occ        <= occ_next;
            dp_ready_q <= allow_next & (occ_next < FULL);
            lfsr_q     <= lfsr_next;
            per_cnt    <= per_cnt_next;
            stalled_q  <= dp_valid & ~dp_ready_q;
            held_pd_q  <= dp_pd;
            // clr wins over a same-cycle accept or error set.
            if (clr) begin
                txn_q    <= '0;
                err_vd_q <= 1'b0;
                err_pc_q <= 1'b0;
            end else begin
                txn_q <= txn_q + {31'd0, accept};
                if (stalled_q && !dp_valid)                       err_vd_q <= 1'b1;
                if (stalled_q && dp_valid && dp_pd != held_pd_q) err_pc_q <= 1'b1;
            end
        end
    end

`ifdef DP_SINK_XCHECK_EN
    logic err_px_q;

    // Sticky flag for accepted payloads holding X/Z.
    always_ff @(posedge clk) begin
        if (!resetn || clr)                       err_px_q <= 1'b0;
        else if (accept && $isunknown(dp_pd))     err_px_q <= 1'b1;
    end
    assign err_pd_x = err_px_q;

    a_pd_known: assert property (@(posedge clk) disable iff (!resetn)
                                 accept |-> !$isunknown(dp_pd));
`else
    assign err_pd_x = 1'b0;
`endif

endmodule
